// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit steps needed to cover the full operand width.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; at least one bit so a single-step adder still has a counter.
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple of full-adder cells.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
module adder_digit
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_top_o
);

  logic [DIGIT:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  // The carry into the top bit is exported so the caller can form signed overflow.
  assign c_o     = c[DIGIT];
  assign c_top_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock.
// Latency: WIDTH/DIGIT RUN cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is ignored while busy; start in the DONE cycle chains without a gap.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_bits(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_ctop;

  // Operands are shifted right each step, so the active digit is always the low slice.
  adder_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .c_i    (carry_q),
    .s_o    (dig_sum),
    .c_o    (dig_cout),
    .c_top_o(dig_ctop)
  );

  // Next-state and datapath update: capture on start, one digit per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // Result digits enter at the top and slide down; after N steps digit 0 sits at bit 0.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_ctop;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at DIGIT = 4, 1 and 16 side by side.
// Latency: checks done arrives N+1 edges after the accepting edge.
// Backpressure: exercises ignored start during RUN and chained start in DONE.
module tb_serial_adder;

  localparam int W = 16;
  localparam int LAT [3] = '{5, 17, 2};

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          start = '0;
  logic                sub = 1'b0;
  logic                cin = 1'b0;
  logic [W-1:0]        a = '0;
  logic [W-1:0]        b = '0;
  logic [2:0]          busy, done, cout, ovf;
  logic [2:0][W-1:0]   sumv;

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy[0]), .done(done[0]), .sum(sumv[0]), .cout(cout[0]), .ovf(ovf[0])
  );
  serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy[1]), .done(done[1]), .sum(sumv[1]), .cout(cout[1]), .ovf(ovf[1])
  );
  serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy[2]), .done(done[2]), .sum(sumv[2]), .cout(cout[2]), .ovf(ovf[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Full-width reference; overflow from operand/result sign bits.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t         r;
    logic [W-1:0] yy;
    logic [W:0]   t;
    yy  = sb ? ~y : y;
    t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    r.s = t[W-1:0];
    r.c = t[W];
    r.v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic score(input int i);
    res_t e;
    logic have;
    have = 1'b0;
    e    = '0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      check($sformatf("d%0d_unexpected_done", i), 32'(done[i]), 32'd0);
    end else begin
      check($sformatf("d%0d_sum", i),  32'(sumv[i]), 32'(e.s));
      check($sformatf("d%0d_cout", i), 32'(cout[i]), 32'(e.c));
      check($sformatf("d%0d_ovf", i),  32'(ovf[i]),  32'(e.v));
    end
  endtask

  // Scoreboard side: every done pulse pops and compares one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (done[i]) score(i);
      end
    end
  end

  task automatic push_exp(input logic [2:0] mask, input res_t e);
    if (mask[0]) q0.push_back(e);
    if (mask[1]) q1.push_back(e);
    if (mask[2]) q2.push_back(e);
  endtask

  // Launch one operation on the selected DUTs; returns in the last DONE cycle.
  task automatic run_op(input logic [2:0] mask, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
    int   lat [3];
    int   nbusy;
    int   n;
    logic all_done;
    @(negedge clk);
    a     = ta;
    b     = tb;
    cin   = tcin;
    sub   = tsub;
    start = mask;
    push_exp(mask, model(ta, tb, tcin, tsub));
    for (int i = 0; i < 3; i++) lat[i] = -1;
    nbusy = 0;
    @(negedge clk);
    start = '0;
    n     = 1;
    while (n <= 40) begin
      if (busy[0]) nbusy++;
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (mask[i] && done[i] && lat[i] < 0) lat[i] = n;
        if (mask[i] && lat[i] < 0) all_done = 1'b0;
      end
      if (all_done) break;
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) check($sformatf("d%0d_latency", i), lat[i], LAT[i]);
    end
    if (mask[0]) check("d0_busy_cycles", nbusy, 4);
  endtask

  // Known vectors on all three widths, checked against literal results.
  task automatic spec_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input logic tsub, input logic [W-1:0] es, input logic ec, input logic ev);
    run_op(3'b111, ta, tb, tcin, tsub);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("vec_d%0d_sum_%h", i, ta), 32'(sumv[i]), 32'(es));
      check($sformatf("vec_d%0d_cout_%h", i, ta), 32'(cout[i]), 32'(ec));
      check($sformatf("vec_d%0d_ovf_%h", i, ta), 32'(ovf[i]), 32'(ev));
    end
  endtask

  // Wait for done on the DIGIT=4 instance, counting edges from the accepting one.
  task automatic wait_d0(input int n0, output int lat);
    int n;
    n   = n0;
    lat = -1;
    while (n <= 40) begin
      if (done[0]) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_d%0d_busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_d%0d_done", i), 32'(done[i]), 32'd0);
      check($sformatf("rst_d%0d_sum", i),  32'(sumv[i]), 32'd0);
      check($sformatf("rst_d%0d_cout", i), 32'(cout[i]), 32'd0);
      check($sformatf("rst_d%0d_ovf", i),  32'(ovf[i]),  32'd0);
    end
    rst = 1'b0;

    spec_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    spec_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    spec_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    spec_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    spec_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // A start pulse with other operands during RUN must be ignored.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 3'b001;
    push_exp(3'b001, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    @(negedge clk);
    start = '0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 3'b001;
    @(negedge clk);
    start = '0;
    wait_d0(3, lat);
    check("midrun_latency", lat, 5);
    @(negedge clk);
    check("midrun_no_restart_busy", 32'(busy[0]), 32'd0);
    check("midrun_no_restart_done", 32'(done[0]), 32'd0);

    // Start held in the DONE cycle chains straight into RUN.
    run_op(3'b001, 16'h0F0F, 16'h00F1, 1'b1, 1'b0);
    a = 16'hC3A5; b = 16'h5A3C; cin = 1'b0; sub = 1'b1; start = 3'b001;
    push_exp(3'b001, model(16'hC3A5, 16'h5A3C, 1'b0, 1'b1));
    @(negedge clk);
    start = '0;
    check("b2b_no_idle_gap", 32'(busy[0]), 32'd1);
    wait_d0(1, lat);
    check("b2b_latency", lat, 5);

    // Reset in the second RUN cycle after an op that left cout/ovf set.
    run_op(3'b001, 16'h8000, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    a = 16'h1357; b = 16'h2468; sub = 1'b0; cin = 1'b0; start = 3'b001;
    @(negedge clk);
    start = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_done", 32'(done[0]), 32'd0);
    check("midrst_sum",  32'(sumv[0]), 32'd0);
    check("midrst_cout", 32'(cout[0]), 32'd0);
    check("midrst_ovf",  32'(ovf[0]),  32'd0);
    // Reset and start together: reset wins.
    start = 3'b001;
    @(negedge clk);
    check("rst_beats_start", 32'(busy[0]), 32'd0);
    start = '0;
    rst   = 1'b0;
    run_op(3'b001, 16'h1357, 16'h2468, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      run_op(3'b111, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("d0_queue_drained", q0.size(), 0);
    check("d1_queue_drained", q1.size(), 0);
    check("d2_queue_drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised two's-complement adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock. It extends the single-bit full-adder primitive with a registered carry chain, an add/subtract mode, a start/busy/done handshake and overflow detection. It sits in the datapath wherever a narrow, area-cheap arithmetic unit is preferred over a full-width combinational adder.

## Interface
- WIDTH, 16, operand and result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 4, bits summed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B+cin, 1 = A−B (computed as A+~B+1, cin ignored).
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- cin  input  1  carry-in for add mode.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB (in sub mode, 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE with start=1:
  - Capture a, and b XOR {WIDTH{sub}}.
  - Set the carry register to (sub ? 1 : cin).
  - Clear the digit counter.
  - Go to RUN.
- DONE with start=0 goes to IDLE. DONE always lasts exactly one cycle.
- RUN, each cycle:
  - Add digit k (bits k·DIGIT+DIGIT−1 : k·DIGIT) of both operands plus the carry register, using a DIGIT-wide ripple of full-adder cells.
  - Write the result digit into the sum register and the digit carry-out into the carry register.
  - Increment k.
- When k = WIDTH/DIGIT−1:
  - Latch cout = final carry-out.
  - Latch ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - Go to DONE.
- start is ignored while in RUN. Operands are not re-sampled during RUN.
- The sum register is written digit by digit. Intermediate sum values are visible during RUN but are not valid until done.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, FSM=IDLE, counter=0.
- Latency: with start accepted at edge 0, RUN occupies edges 1..N, where N = WIDTH/DIGIT.
- done=1 and valid sum/cout/ovf appear in the cycle after edge N. done drops one cycle later.
- busy=1 for exactly N cycles.
- Back-to-back operation: start=1 during the DONE cycle is accepted. Throughput is one result per N+1 cycles.
- rst=1 in any state, including mid-RUN, returns all outputs to their reset values on the next edge. The partial result is discarded.
- rst and start asserted together: rst wins.
- DIGIT = WIDTH (N=1): RUN lasts one cycle, and done follows 2 edges after start.

## Structure
- Shared package `adder_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - localparam-style helper for N = WIDTH/DIGIT.
  - Counter width computed as clog2(N), minimum 1.
- One sub-module `adder_digit`, parametrised by DIGIT:
  - Purely combinational ripple of single-bit sum/carry cells.
  - Outputs the digit sum, the carry-out, and the carry into its top bit (needed for ovf).
- Top level holds the FSM, operand shift/index logic, carry register and output registers.
- Elaboration-time check that WIDTH % DIGIT == 0.

## Test plan
- WIDTH=16, DIGIT=4, add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; done 5 cycles after start; busy high for 4 cycles.
- Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Then add 0x1234+0x4321 with cin=1 -> sum=0x5556, cout=0, ovf=0.
- sub=1, 0x0005−0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then sub=1, 0x8000−0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Pulse start again during RUN with different operands -> ignored; first result delivered unchanged. Start held high in the DONE cycle -> second operation accepted with no IDLE gap.
- Assert rst at the second RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; a subsequent start completes normally.
- Rerun the first three scenarios with DIGIT=1 and DIGIT=16 -> identical results; latency 17 and 2 cycles respectively. Randomised compare against a behavioural model for 1000 operations.
